// File: rtl/wmem_access_sched.sv
// Weight-memory access scheduler: one read and one write requester onto the single wrapper port.
// Optional per-bank deep-sleep control is compiled in with `define WMEM_SLEEP_EN.
module wmem_access_sched #(
   parameter int DATA_BIT        = 128,
   parameter int WMEM_DEPTH      = 1536,
   parameter int WMEM_ADDR_WIDTH = $clog2(WMEM_DEPTH),
   parameter int ATTN_DEPTH      = 512,
   parameter int MAX_WAIT        = 8,
   parameter int IDLE_THRESH     = 64,
   parameter int WAKE_CYCLES     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [WMEM_ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_BIT-1:0]        wr_data,
   input  logic [DATA_BIT-1:0]        wr_bwe,
   input  logic                       rd_valid,
   output logic                       rd_ready,
   input  logic [WMEM_ADDR_WIDTH-1:0] rd_addr,
   output logic                       rd_rvalid,
   output logic [DATA_BIT-1:0]        rd_rdata,
   output logic                       err_oor,
   output logic [WMEM_ADDR_WIDTH-1:0] wmem_addr,
   output logic                       wmem_ren,
   output logic                       wmem_wen,
   output logic [DATA_BIT-1:0]        wmem_wdata,
   output logic [DATA_BIT-1:0]        wmem_bwe,
   input  logic [DATA_BIT-1:0]        wmem_rdata,
   output logic                       wmem_512_attn_deepslp,
   output logic                       wmem_1024_ffn_deepslp
);
   localparam int AW = WMEM_ADDR_WIDTH;
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic          rd_oor, wr_oor;
   logic          rd_ffn, wr_ffn;
   logic [1:0]    act;
   logic          rd_ok, wr_ok;
   logic          wait_max;
   logic          rd_acc, wr_acc;
   logic [WW-1:0] wait_q, wait_d;
   logic          rvalid_q, rinr_q, err_q;

   assign rd_oor = {1'b0, rd_addr} >= (AW+1)'(WMEM_DEPTH);
   assign wr_oor = {1'b0, wr_addr} >= (AW+1)'(WMEM_DEPTH);
   assign rd_ffn = rd_addr >= AW'(ATTN_DEPTH);
   assign wr_ffn = wr_addr >= AW'(ATTN_DEPTH);

   // out-of-range requests never touch a bank, so they bypass bank state
   assign rd_ok = rd_oor | act[rd_ffn];
   assign wr_ok = wr_oor | act[wr_ffn];

   assign wait_max = (wait_q == WW'(MAX_WAIT));
   assign rd_ready = ~rst & rd_ok & ~(wr_valid & wr_ok & wait_max);
   assign wr_ready = ~rst & wr_ok & (~(rd_valid & rd_ok) | wait_max);
   assign rd_acc   = rd_valid & rd_ready;
   assign wr_acc   = wr_valid & wr_ready;

   assign wmem_ren   = rd_acc & ~rd_oor;
   assign wmem_wen   = wr_acc & ~wr_oor;
   assign wmem_addr  = wr_acc ? wr_addr : rd_addr;
   assign wmem_wdata = wr_acc ? wr_data : '0;
   assign wmem_bwe   = wr_acc ? wr_bwe : '0;

   always_comb begin
      wait_d = wait_q;
      if (wr_acc)
         wait_d = '0;
      else if (wr_valid & wr_ok & rd_acc & ~wait_max)
         wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q   <= '0;
         rvalid_q <= 1'b0;
         rinr_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wait_q   <= wait_d;
         rvalid_q <= rd_acc;
         rinr_q   <= rd_acc & ~rd_oor;
         err_q    <= (rd_acc & rd_oor) | (wr_acc & wr_oor);
      end
   end

   assign rd_rvalid = rvalid_q;
   assign rd_rdata  = rinr_q ? wmem_rdata : '0;
   assign err_oor   = err_q;

`ifdef WMEM_SLEEP_EN
   typedef enum logic [1:0] {B_ACTIVE, B_SLEEP, B_WAKE} bank_e;
   localparam int IW = $clog2(IDLE_THRESH);
   localparam int KW = $clog2(WAKE_CYCLES + 1);

   logic [1:0] slp;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      bank_e         st_q;
      logic [IW-1:0] idle_q;
      logic [KW-1:0] wake_q;
      logic          acc, req;

      assign acc = (rd_acc & ~rd_oor & (rd_ffn == 1'(b)))
                 | (wr_acc & ~wr_oor & (wr_ffn == 1'(b)));
      assign req = (rd_valid & ~rd_oor & (rd_ffn == 1'(b)))
                 | (wr_valid & ~wr_oor & (wr_ffn == 1'(b)));

      // idle_q lags the idle-cycle count by one, so sleep lands IDLE_THRESH
      // cycles after the last accept
      always_ff @(posedge clk) begin
         if (rst) begin
            st_q   <= B_ACTIVE;
            idle_q <= '0;
            wake_q <= '0;
         end else begin
            case (st_q)
               B_ACTIVE: begin
                  if (acc) begin
                     idle_q <= '0;
                  end else if (idle_q == IW'(IDLE_THRESH - 2)) begin
                     st_q   <= B_SLEEP;
                     idle_q <= '0;
                  end else begin
                     idle_q <= idle_q + 1'b1;
                  end
               end
               B_SLEEP: begin
                  if (req) begin
                     st_q   <= B_WAKE;
                     wake_q <= KW'(WAKE_CYCLES - 1);
                  end
               end
               B_WAKE: begin
                  if (wake_q == '0)
                     st_q <= B_ACTIVE;
                  else
                     wake_q <= wake_q - 1'b1;
               end
               default: st_q <= B_ACTIVE;
            endcase
         end
      end

      assign act[b] = (st_q == B_ACTIVE);
      assign slp[b] = (st_q == B_SLEEP);
   end

   assign wmem_512_attn_deepslp = slp[0];
   assign wmem_1024_ffn_deepslp = slp[1];
`else
   assign act                   = 2'b11;
   assign wmem_512_attn_deepslp = 1'b0;
   assign wmem_1024_ffn_deepslp = 1'b0;
`endif

endmodule
